// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues one imem request at a time and
// presents {pc, inst} to decode. Optional stall counter built when FETCH_STALL_CNT_EN is defined.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_target,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_out_valid,
  output logic [31:0] o_out_pc,
  output logic [31:0] o_out_inst,
  input  logic        i_out_ready,
  output logic [31:0] o_stall_cycles
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   w_pc_nxt;
  logic              r_discard;
  logic              w_discard_nxt;
  logic              r_imem_req;
  logic              r_out_valid;
  logic              w_out_valid_nxt;
  logic [XLEN-1:0]   r_out_pc;
  logic [XLEN-1:0]   w_out_pc_nxt;
  logic [XLEN-1:0]   r_out_inst;
  logic [XLEN-1:0]   w_out_inst_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath update decisions
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_discard_nxt   = r_discard;
    w_out_valid_nxt = r_out_valid;
    w_out_pc_nxt    = r_out_pc;
    w_out_inst_nxt  = r_out_inst;

    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
        if (i_redirect_valid) begin
          w_pc_nxt = i_redirect_target;
        end
      end

      S_REQ: begin
        if (i_redirect_valid) begin
          w_pc_nxt = i_redirect_target;
        end
        if (i_imem_gnt) begin
          w_state_nxt   = S_WAIT;
          w_discard_nxt = i_redirect_valid;
        end
      end

      S_WAIT: begin
        if (i_imem_rvalid) begin
          if (r_discard || i_redirect_valid) begin
            // Wrong-path response: drop it and refetch from the current/new PC
            w_discard_nxt = 1'b0;
            w_state_nxt   = S_REQ;
            if (i_redirect_valid) begin
              w_pc_nxt = i_redirect_target;
            end
          end else begin
            w_out_valid_nxt = 1'b1;
            w_out_pc_nxt    = r_pc;
            w_out_inst_nxt  = i_imem_rdata;
            w_pc_nxt        = r_pc + XLEN'(PC_STEP);
            w_state_nxt     = S_HOLD;
          end
        end else if (i_redirect_valid) begin
          w_discard_nxt = 1'b1;
          w_pc_nxt      = i_redirect_target;
        end
      end

      S_HOLD: begin
        if (i_redirect_valid) begin
          w_out_valid_nxt = 1'b0;
          w_pc_nxt        = i_redirect_target;
          w_state_nxt     = S_REQ;
        end else if (i_out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_REQ;
        end
      end

      default: ;
    endcase
  end

  // Datapath registers; req is registered from the next state so it equals (state == REQ)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_discard   <= 1'b0;
      r_imem_req  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_out_inst  <= '0;
    end else begin
      r_pc        <= w_pc_nxt;
      r_discard   <= w_discard_nxt;
      r_imem_req  <= (w_state_nxt == S_REQ);
      r_out_valid <= w_out_valid_nxt;
      r_out_pc    <= w_out_pc_nxt;
      r_out_inst  <= w_out_inst_nxt;
    end
  end

  assign o_imem_req  = r_imem_req;
  assign o_imem_addr = r_pc;
  assign o_out_valid = r_out_valid;
  assign o_out_pc    = r_out_pc;
  assign o_out_inst  = r_out_inst;

`ifdef FETCH_STALL_CNT_EN
  logic            w_stall;
  logic [XLEN-1:0] r_stall_cnt;

  assign w_stall = ((r_state == S_REQ) && !i_imem_gnt) ||
                   ((r_state == S_HOLD) && !i_out_ready);

  // Free-running modulo-2^32 stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall) begin
      r_stall_cnt <= r_stall_cnt + XLEN'(1);
    end
  end

  assign o_stall_cycles = r_stall_cnt;
`else
  assign o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, hand-placed corner checks and a
// randomized run compared every cycle against a transaction-level reference model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        redir;
  logic [31:0] tgt;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        ready;

  logic        req,  d2_req;
  logic [31:0] addr, d2_addr;
  logic        ov,   d2_ov;
  logic [31:0] opc,  d2_opc;
  logic [31:0] oinst, d2_oinst;
  logic [31:0] stall, d2_stall;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_ctrl u_dut (
    .clk(clk), .rst(rst),
    .i_redirect_valid(redir), .i_redirect_target(tgt),
    .o_imem_req(req), .o_imem_addr(addr),
    .i_imem_gnt(gnt), .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
    .o_out_valid(ov), .o_out_pc(opc), .o_out_inst(oinst),
    .i_out_ready(ready), .o_stall_cycles(stall)
  );

  fetch_ctrl #(.RESET_PC(32'hFFFFFFFC)) u_dut_wrap (
    .clk(clk), .rst(rst),
    .i_redirect_valid(redir), .i_redirect_target(tgt),
    .o_imem_req(d2_req), .o_imem_addr(d2_addr),
    .i_imem_gnt(gnt), .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
    .o_out_valid(d2_ov), .o_out_pc(d2_opc), .o_out_inst(d2_oinst),
    .i_out_ready(ready), .o_stall_cycles(d2_stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the fetch as a transaction (pending request, in-flight
  // response that may be stale, presented instruction) rather than as FSM states.
  logic        m_boot, m_pending, m_inflight, m_stale, m_ov;
  logic [31:0] m_pc, m_opc, m_oinst, m_stall;

  always @(posedge clk) begin
    if (rst) begin
      m_boot = 1'b1; m_pending = 1'b0; m_inflight = 1'b0; m_stale = 1'b0;
      m_ov = 1'b0; m_pc = 32'hBFC00000; m_opc = 32'h0; m_oinst = 32'h0; m_stall = 32'h0;
    end else begin
      if ((m_pending && !gnt) || (m_ov && !ready)) m_stall = m_stall + 32'd1;
      if (m_boot) begin
        m_boot = 1'b0;
        m_pending = 1'b1;
        if (redir) m_pc = tgt;
      end else if (m_pending) begin
        if (redir) m_pc = tgt;
        if (gnt) begin
          m_pending = 1'b0; m_inflight = 1'b1; m_stale = redir;
        end
      end else if (m_inflight) begin
        if (rvalid) begin
          m_inflight = 1'b0;
          if (m_stale || redir) begin
            m_stale = 1'b0; m_pending = 1'b1;
            if (redir) m_pc = tgt;
          end else begin
            m_ov = 1'b1; m_opc = m_pc; m_oinst = rdata; m_pc = m_pc + 32'd4;
          end
        end else if (redir) begin
          m_stale = 1'b1; m_pc = tgt;
        end
      end else if (m_ov) begin
        if (redir) begin
          m_ov = 1'b0; m_pc = tgt; m_pending = 1'b1;
        end else if (ready) begin
          m_ov = 1'b0; m_pending = 1'b1;
        end
      end
    end
  end

  typedef struct {
    logic        rst, redir;
    logic [31:0] tgt;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ov;
    logic [31:0] e_pc, e_inst;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic rd, logic [31:0] t, logic g, logic rv,
                              logic [31:0] d, logic rdy, logic eq, logic [31:0] ea,
                              logic eo, logic [31:0] ep, logic [31:0] ei);
    vec_t v;
    v.rst = r; v.redir = rd; v.tgt = t; v.gnt = g; v.rvalid = rv; v.rdata = d; v.ready = rdy;
    v.e_req = eq; v.e_addr = ea; v.e_ov = eo; v.e_pc = ep; v.e_inst = ei;
    return v;
  endfunction

  task automatic step(input logic r, input logic rd, input logic [31:0] t, input logic g,
                      input logic rv, input logic [31:0] d, input logic rdy);
    rst = r; redir = rd; tgt = t; gnt = g; rvalid = rv; rdata = d; ready = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] stall_base;
  logic [31:0] exp_stall;

  initial begin
    rst = 1'b1; redir = 1'b0; tgt = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0; ready = 1'b0;
    stall_base = '0;

    // rst redir tgt gnt rv rdata ready | req addr ov pc inst
    vecs.push_back(mk(1,0,32'h0,0,0,32'h0,0,             0,32'hBFC00000,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,0,             1,32'hBFC00000,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,32'h0,1,0,32'h0,0,             0,32'hBFC00000,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,1,32'h11111111,0,      0,32'hBFC00004,1,32'hBFC00000,32'h11111111));
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,1,             1,32'hBFC00004,0,32'hBFC00000,32'h11111111));
    vecs.push_back(mk(0,0,32'h0,1,0,32'h0,0,             0,32'hBFC00004,0,32'hBFC00000,32'h11111111));
    vecs.push_back(mk(0,0,32'h0,0,1,32'h22222222,1,      0,32'hBFC00008,1,32'hBFC00004,32'h22222222));
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,1,             1,32'hBFC00008,0,32'hBFC00004,32'h22222222));
    vecs.push_back(mk(0,0,32'h0,1,0,32'h0,0,             0,32'hBFC00008,0,32'hBFC00004,32'h22222222));
    vecs.push_back(mk(0,1,32'h80001000,0,0,32'h0,0,      0,32'h80001000,0,32'hBFC00004,32'h22222222));
    vecs.push_back(mk(0,0,32'h0,0,1,32'hDEADBEEF,0,      1,32'h80001000,0,32'hBFC00004,32'h22222222));
    vecs.push_back(mk(0,0,32'h0,1,0,32'h0,0,             0,32'h80001000,0,32'hBFC00004,32'h22222222));
    vecs.push_back(mk(0,0,32'h0,0,1,32'h33333333,0,      0,32'h80001004,1,32'h80001000,32'h33333333));
    vecs.push_back(mk(0,1,32'h00000040,0,0,32'h0,1,      1,32'h00000040,0,32'h80001000,32'h33333333));
    vecs.push_back(mk(0,1,32'h00000100,1,0,32'h0,0,      0,32'h00000100,0,32'h80001000,32'h33333333));
    vecs.push_back(mk(0,0,32'h0,0,1,32'h44444444,0,      1,32'h00000100,0,32'h80001000,32'h33333333));
    vecs.push_back(mk(0,1,32'h00000200,0,0,32'h0,0,      1,32'h00000200,0,32'h80001000,32'h33333333));
    vecs.push_back(mk(0,0,32'h0,1,0,32'h0,0,             0,32'h00000200,0,32'h80001000,32'h33333333));
    vecs.push_back(mk(0,0,32'h0,0,1,32'h55555555,0,      0,32'h00000204,1,32'h00000200,32'h55555555));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0,0,32'h0,1,1,32'h66666666,0,    0,32'h00000204,1,32'h00000200,32'h55555555));
    vecs.push_back(mk(0,0,32'h0,0,0,32'h0,1,             1,32'h00000204,0,32'h00000200,32'h55555555));
    vecs.push_back(mk(0,0,32'h0,1,0,32'h0,0,             0,32'h00000204,0,32'h00000200,32'h55555555));
    vecs.push_back(mk(1,0,32'h0,0,0,32'h0,0,             0,32'hBFC00000,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,1,32'h77777777,0,      1,32'hBFC00000,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,1,32'h77777777,0,      1,32'hBFC00000,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,32'h0,1,0,32'h0,0,             0,32'hBFC00000,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,1,32'h88888888,0,      0,32'hBFC00004,1,32'hBFC00000,32'h88888888));
    vecs.push_back(mk(1,0,32'h0,0,0,32'h0,0,             0,32'hBFC00000,0,32'h0,32'h0));
    vecs.push_back(mk(0,1,32'h00001000,0,0,32'h0,0,      1,32'h00001000,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,32'h0,1,1,32'h99999999,0,      0,32'h00001000,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,32'h0,0,1,32'hAAAAAAAA,0,      0,32'h00001004,1,32'h00001000,32'hAAAAAAAA));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].redir, vecs[i].tgt, vecs[i].gnt, vecs[i].rvalid,
           vecs[i].rdata, vecs[i].ready);
      chk($sformatf("vec%0d req", i),  {31'h0, req}, {31'h0, vecs[i].e_req});
      chk($sformatf("vec%0d addr", i), addr,         vecs[i].e_addr);
      chk($sformatf("vec%0d valid", i),{31'h0, ov},  {31'h0, vecs[i].e_ov});
      chk($sformatf("vec%0d pc", i),   opc,          vecs[i].e_pc);
      chk($sformatf("vec%0d inst", i), oinst,        vecs[i].e_inst);
`ifdef FETCH_STALL_CNT_EN
      if (i == 18) stall_base = stall;
      if (i == 23) chk("hold_stall_delta", stall - stall_base, 32'd5);
`else
      chk($sformatf("vec%0d stall", i), stall, 32'h0);
`endif
      if (i == 3) begin
        chk("wrap_second_addr", d2_addr, 32'h00000000);
        chk("wrap_first_pc",    d2_opc,  32'hFFFFFFFC);
        chk("wrap_valid",       {31'h0, d2_ov}, 32'h1);
      end
    end

    // Randomized run against the reference model
    step(1, 0, 32'h0, 0, 0, 32'h0, 0);
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(63) == 0), ($urandom_range(7) == 0),
           {$urandom_range(32'h3FFFFFFF), 2'b00}, 1'($urandom_range(1)),
           1'($urandom_range(1)), $urandom, 1'($urandom_range(1)));
      chk("rnd req",   {31'h0, req}, {31'h0, m_pending});
      chk("rnd addr",  addr,         m_pc);
      chk("rnd valid", {31'h0, ov},  {31'h0, m_ov});
      chk("rnd pc",    opc,          m_opc);
      chk("rnd inst",  oinst,        m_oinst);
`ifdef FETCH_STALL_CNT_EN
      exp_stall = m_stall;
`else
      exp_stall = 32'h0;
`endif
      chk("rnd stall", stall, exp_stall);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
